// File: rtl/spi_arb_if.sv
// Bundle of requester and SPI-master signals shared by the two-port SPI arbiter.
// The slave modport is the arbiter's view; the master modport is the view of whatever drives it.
interface spi_arb_if;
    logic       req0, req1;
    logic       wr0, wr1;
    logic [7:0] addr0, addr1;
    logic [7:0] din0, din1;
    logic       ack0, ack1;
    logic [7:0] rdata0, rdata1;
    logic       err0, err1;
    logic       m_wr;
    logic [7:0] m_addr;
    logic [7:0] m_din;
    logic       m_valid;
    logic       m_done;
    logic       m_err;
    logic [7:0] m_dout;

    modport slave (
        input  req0, req1, wr0, wr1, addr0, addr1, din0, din1,
        input  m_done, m_err, m_dout,
        output ack0, ack1, rdata0, rdata1, err0, err1,
        output m_wr, m_addr, m_din, m_valid
    );

    modport master (
        output req0, req1, wr0, wr1, addr0, addr1, din0, din1,
        output m_done, m_err, m_dout,
        input  ack0, ack1, rdata0, rdata1, err0, err1,
        input  m_wr, m_addr, m_din, m_valid
    );
endinterface

// File: rtl/spi_arb.sv
// Two-requester round-robin arbiter in front of a single SPI master, with address
// range rejection (addr > 31) and a downstream completion timeout.
module spi_arb #(
    parameter int unsigned TIMEOUT = 64
) (
    input logic      clk,
    input logic      rst,
    spi_arb_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 2);
    localparam logic [7:0] ADDR_MAX = 8'd31;

    state_t     state;
    logic       last_gnt;
    logic       win;
    logic [7:0] cnt;
    logic       lat_wr;
    logic [7:0] lat_addr;
    logic [7:0] lat_din;
    logic [7:0] res_data;
    logic       res_err;

    logic       pick;
    logic       pick_wr;
    logic [7:0] pick_addr;
    logic [7:0] pick_din;

    // With both requesting, the port not granted last wins; otherwise the lone requester wins.
    always_comb begin
        pick = 1'b0;
        if (bus.req0 && bus.req1)
            pick = ~last_gnt;
        else if (bus.req1)
            pick = 1'b1;
        pick_wr   = pick ? bus.wr1   : bus.wr0;
        pick_addr = pick ? bus.addr1 : bus.addr0;
        pick_din  = pick ? bus.din1  : bus.din0;
    end

    // NOTE: non-blocking assignments throughout so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_gnt   <= 1'b1;
            win        <= 1'b0;
            cnt        <= '0;
            lat_wr     <= 1'b0;
            lat_addr   <= '0;
            lat_din    <= '0;
            res_data   <= '0;
            res_err    <= 1'b0;
            bus.ack0   <= 1'b0;
            bus.ack1   <= 1'b0;
            bus.rdata0 <= '0;
            bus.rdata1 <= '0;
            bus.err0   <= 1'b0;
            bus.err1   <= 1'b0;
            bus.m_wr   <= 1'b0;
            bus.m_addr <= '0;
            bus.m_din  <= '0;
            bus.m_valid <= 1'b0;
        end else begin
            // NOTE: acks default low every cycle, so they can only ever be one-cycle pulses.
            bus.ack0 <= 1'b0;
            bus.ack1 <= 1'b0;

            case (state)
                IDLE: begin
                    if (bus.req0 || bus.req1) begin
                        win      <= pick;
                        lat_wr   <= pick_wr;
                        lat_addr <= pick_addr;
                        lat_din  <= pick_din;
                        if (pick_addr > ADDR_MAX) begin
                            res_err  <= 1'b1;
                            res_data <= '0;
                            state    <= RESP;
                        end else begin
                            state <= ISSUE;
                        end
                    end
                end

                ISSUE: begin
                    bus.m_valid <= 1'b1;
                    bus.m_wr    <= lat_wr;
                    bus.m_addr  <= lat_addr;
                    bus.m_din   <= lat_din;
                    cnt         <= '0;
                    state       <= WAIT;
                end

                WAIT: begin
                    cnt <= cnt + 8'd1;
                    if (bus.m_done) begin
                        res_err     <= bus.m_err;
                        res_data    <= lat_wr ? 8'h00 : bus.m_dout;
                        bus.m_valid <= 1'b0;
                        state       <= RESP;
                    end else if (cnt == CNT_LAST) begin
                        // Counter is about to read TIMEOUT-1 with no completion: give up.
                        res_err     <= 1'b1;
                        res_data    <= '0;
                        bus.m_valid <= 1'b0;
                        state       <= RESP;
                    end
                end

                RESP: begin
                    if (win) begin
                        bus.ack1   <= 1'b1;
                        bus.rdata1 <= res_data;
                        bus.err1   <= res_err;
                    end else begin
                        bus.ack0   <= 1'b1;
                        bus.rdata0 <= res_data;
                        bus.err0   <= res_err;
                    end
                    bus.m_valid <= 1'b0;
                    last_gnt    <= win;
                    cnt         <= '0;
                    state       <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end
endmodule
